shiftreg_tap_delay: RTL and testbench

Parametrised shift-register delay line: WIDTH-bit words advance through DEPTH register stages on each enabled clock edge. A runtime-selectable tap returns the word delayed by 1..DEPTH enabled cycles, with a validity flag derived from a fill counter. Used as the generic delay/alignment element in the sequential datapaths, replacing fixed-depth, fixed-width cascaded registers.

---
 rtl/shiftreg_tap_delay.sv | 97 +++++++++
 tb/tb_shiftreg_tap_delay.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_tap_delay.sv
// Parametrised WIDTH x DEPTH shift-register delay line with a runtime tap select,
// per-tap validity from a saturating fill counter, and a fixed full-depth tap.
module shiftreg_tap_delay #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int SELW  = $clog2(DEPTH),
   localparam int CNTW  = $clog2(DEPTH + 1)
) (
   input  logic             ck,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   input  logic [SELW-1:0]  tap_sel,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   output logic [WIDTH-1:0] dlast,
   output logic             full,
   output logic [CNTW-1:0]  fill
);

   localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(DEPTH);
   localparam logic [CNTW-1:0] CNT_ONE_C = CNTW'(1);
   localparam logic [SELW:0]   DEPTH_S   = (SELW + 1)'(DEPTH);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];
   logic [CNTW-1:0]  fill_q;
   logic [CNTW-1:0]  fill_d;

   logic             tap_ok_s;
   logic [CNTW:0]    tap_ext_s;
   logic [CNTW:0]    fill_ext_s;
   logic [WIDTH-1:0] dout_s;

   // Next-state: clear beats shift; the fill count saturates at DEPTH.
   always_comb begin
      stage_d = stage_q;
      fill_d  = fill_q;
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = '0;
         end
         fill_d = '0;
      end else if (en) begin
         stage_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
         end
         if (fill_q < DEPTH_C) begin
            fill_d = fill_q + CNT_ONE_C;
         end else begin
            fill_d = fill_q;
         end
      end else begin
         stage_d = stage_q;
         fill_d  = fill_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
         fill_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
         fill_q <= fill_d;
      end
   end

   // Tap mux: unmatched selects (only when DEPTH is not a power of two) read zero.
   always_comb begin
      dout_s     = '0;
      tap_ok_s   = ({1'b0, tap_sel} < DEPTH_S);
      tap_ext_s  = (CNTW + 1)'(tap_sel);
      fill_ext_s = {1'b0, fill_q};
      for (int i = 0; i < DEPTH; i++) begin
         if (tap_sel == SELW'(i)) begin
            dout_s = stage_q[i];
         end else begin
            dout_s = dout_s;
         end
      end
   end

   assign dout       = dout_s;
   assign dout_valid = tap_ok_s && (fill_ext_s > tap_ext_s);
   assign dlast      = stage_q[DEPTH-1];
   assign full       = (fill_q == DEPTH_C);
   assign fill       = fill_q;

endmodule

// File: tb/tb_shiftreg_tap_delay.sv
// Scoreboard bench for shiftreg_tap_delay: a DEPTH=4 and a DEPTH=3 instance share
// the data inputs; a behavioural model queues expected outputs for every edge.
module tb_shiftreg_tap_delay;

   logic       ck = 1'b0;
   logic       reset;
   logic       en;
   logic       clr;
   logic [7:0] din;
   logic [1:0] tap_sel;
   logic [1:0] tap_sel3;

   logic [7:0] dout4, dlast4, dout3, dlast3;
   logic       dv4, full4, dv3, full3;
   logic [2:0] fill4;
   logic [1:0] fill3;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] dout;
      logic       dv;
      logic [7:0] dlast;
      logic       full;
      logic [2:0] fill;
   } exp_t;

   exp_t sb4[$];
   exp_t sb3[$];

   logic [7:0] m4 [4];
   logic [7:0] m3 [3];
   int         f4;
   int         f3;

   shiftreg_tap_delay #(.WIDTH(8), .DEPTH(4)) u_dut4 (
      .ck(ck), .reset(reset), .en(en), .clr(clr), .din(din), .tap_sel(tap_sel),
      .dout(dout4), .dout_valid(dv4), .dlast(dlast4), .full(full4), .fill(fill4)
   );

   shiftreg_tap_delay #(.WIDTH(8), .DEPTH(3)) u_dut3 (
      .ck(ck), .reset(reset), .en(en), .clr(clr), .din(din), .tap_sel(tap_sel3),
      .dout(dout3), .dout_valid(dv3), .dlast(dlast3), .full(full3), .fill(fill3)
   );

   always #5 ck = ~ck;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model4();
      exp_t e;
      e.dout  = m4[tap_sel];
      e.dv    = (f4 > int'(tap_sel));
      e.dlast = m4[3];
      e.full  = (f4 == 4);
      e.fill  = 3'(f4);
      return e;
   endfunction

   function automatic exp_t model3();
      exp_t e;
      int   t;
      t       = int'(tap_sel3);
      e.dout  = (t < 3) ? m3[t] : 8'h00;
      e.dv    = (t < 3) && (f3 > t);
      e.dlast = m3[2];
      e.full  = (f3 == 3);
      e.fill  = 3'(f3);
      return e;
   endfunction

   task automatic model_zero();
      for (int i = 0; i < 4; i++) m4[i] = 8'h00;
      for (int i = 0; i < 3; i++) m3[i] = 8'h00;
      f4 = 0;
      f3 = 0;
   endtask

   task automatic compare_now();
      exp_t e4;
      exp_t e3;
      e4 = model4();
      e3 = model3();
      check_value("d4_dout",  dout4,  e4.dout);
      check_value("d4_valid", dv4,    e4.dv);
      check_value("d4_dlast", dlast4, e4.dlast);
      check_value("d4_full",  full4,  e4.full);
      check_value("d4_fill",  fill4,  e4.fill);
      check_value("d3_dout",  dout3,  e3.dout);
      check_value("d3_valid", dv3,    e3.dv);
      check_value("d3_dlast", dlast3, e3.dlast);
      check_value("d3_full",  full3,  e3.full);
      check_value("d3_fill",  {1'b0, fill3}, e3.fill);
   endtask

   // Drive one edge, update the model, queue expectations, compare after the edge.
   task automatic cycle(input logic e_i, input logic c_i, input logic [7:0] d_i);
      exp_t e4;
      exp_t e3;
      en  = e_i;
      clr = c_i;
      din = d_i;
      if (c_i) begin
         model_zero();
      end else if (e_i) begin
         for (int i = 3; i > 0; i--) m4[i] = m4[i-1];
         m4[0] = d_i;
         for (int i = 2; i > 0; i--) m3[i] = m3[i-1];
         m3[0] = d_i;
         if (f4 < 4) f4++;
         if (f3 < 3) f3++;
      end
      sb4.push_back(model4());
      sb3.push_back(model3());
      @(posedge ck);
      #1;
      e4 = sb4.pop_front();
      e3 = sb3.pop_front();
      check_value("sb4_dout",  dout4,  e4.dout);
      check_value("sb4_valid", dv4,    e4.dv);
      check_value("sb4_dlast", dlast4, e4.dlast);
      check_value("sb4_full",  full4,  e4.full);
      check_value("sb4_fill",  fill4,  e4.fill);
      check_value("sb3_dout",  dout3,  e3.dout);
      check_value("sb3_valid", dv3,    e3.dv);
      check_value("sb3_dlast", dlast3, e3.dlast);
      check_value("sb3_full",  full3,  e3.full);
      check_value("sb3_fill",  {1'b0, fill3}, e3.fill);
      en  = 1'b0;
      clr = 1'b0;
   endtask

   initial begin
      logic [7:0] sweep [4];
      sweep[0] = 8'h44; sweep[1] = 8'h33; sweep[2] = 8'h22; sweep[3] = 8'h11;

      reset    = 1'b1;
      en       = 1'b0;
      clr      = 1'b0;
      din      = 8'h00;
      tap_sel  = 2'd3;
      tap_sel3 = 2'd2;
      model_zero();
      repeat (2) @(posedge ck);
      #1;
      check_value("rst_dout",  dout4,  8'h00);
      check_value("rst_valid", dv4,    1'b0);
      check_value("rst_dlast", dlast4, 8'h00);
      check_value("rst_full",  full4,  1'b0);
      check_value("rst_fill",  fill4,  3'd0);
      @(negedge ck);
      reset = 1'b0;

      // Fill and stream.
      cycle(1'b1, 1'b0, 8'h11);
      cycle(1'b1, 1'b0, 8'h22);
      cycle(1'b1, 1'b0, 8'h33);
      check_value("fill3_full", full4, 1'b0);
      cycle(1'b1, 1'b0, 8'h44);
      check_value("fill_dout",  dout4, 8'h11);
      check_value("fill_valid", dv4,   1'b1);
      check_value("fill_full",  full4, 1'b1);
      check_value("fill_fill",  fill4, 3'd4);
      check_value("d3_full_at3", full3, 1'b1);

      // Tap sweep, combinational from tap_sel.
      for (int t = 0; t < 4; t++) begin
         tap_sel = 2'(t);
         #1;
         check_value("sweep_dout",  dout4, sweep[t]);
         check_value("sweep_valid", dv4,   1'b1);
      end
      tap_sel  = 2'd3;
      tap_sel3 = 2'd3;
      #1;
      check_value("np2_dout",  dout3,  8'h00);
      check_value("np2_valid", dv3,    1'b0);
      check_value("np2_dlast", dlast3, 8'h22);

      cycle(1'b1, 1'b0, 8'h55);
      check_value("stream_dout", dout4, 8'h22);
      check_value("stream_fill", fill4, 3'd4);
      check_value("np2_dlast2",  dlast3, 8'h33);

      // Reset mid-run, between edges.
      #3;
      reset = 1'b1;
      #1;
      check_value("mid_rst_dout",  dout4,  8'h00);
      check_value("mid_rst_dlast", dlast4, 8'h00);
      check_value("mid_rst_fill",  fill4,  3'd0);
      check_value("mid_rst_full",  full4,  1'b0);
      model_zero();
      @(negedge ck);
      reset = 1'b0;

      // Partial fill.
      tap_sel  = 2'd2;
      tap_sel3 = 2'd2;
      cycle(1'b1, 1'b0, 8'hA1);
      check_value("first_fill", fill4, 3'd1);
      cycle(1'b1, 1'b0, 8'hB2);
      check_value("part_valid", dv4,   1'b0);
      check_value("part_fill",  fill4, 3'd2);

      // Enable gating.
      cycle(1'b0, 1'b1, 8'h00);
      cycle(1'b1, 1'b0, 8'h01);
      cycle(1'b1, 1'b0, 8'h02);
      repeat (3) cycle(1'b0, 1'b0, 8'hFF);
      cycle(1'b1, 1'b0, 8'h03);
      check_value("gate_dout",  dout4, 8'h01);
      check_value("gate_fill",  fill4, 3'd3);
      check_value("gate_valid", dv4,   1'b1);
      tap_sel = 2'd0;
      #1;
      check_value("gate_s0", dout4, 8'h03);
      tap_sel = 2'd1;
      #1;
      check_value("gate_s1", dout4, 8'h02);

      // clr priority over en.
      cycle(1'b1, 1'b0, 8'h04);
      check_value("pre_clr_full", full4, 1'b1);
      cycle(1'b1, 1'b1, 8'h77);
      check_value("clr_fill",  fill4,  3'd0);
      check_value("clr_full",  full4,  1'b0);
      check_value("clr_dlast", dlast4, 8'h00);
      for (int t = 0; t < 4; t++) begin
         tap_sel = 2'(t);
         #1;
         check_value("clr_stage", dout4, 8'h00);
      end
      tap_sel = 2'd0;
      cycle(1'b1, 1'b0, 8'h88);
      check_value("post_clr_fill", fill4, 3'd1);
      check_value("post_clr_s0",   dout4, 8'h88);

      // Random traffic against the model.
      for (int n = 0; n < 200; n++) begin
         tap_sel  = 2'($urandom_range(0, 3));
         tap_sel3 = 2'($urandom_range(0, 3));
         cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
               8'($urandom_range(0, 255)));
         tap_sel  = 2'($urandom_range(0, 3));
         tap_sel3 = 2'($urandom_range(0, 3));
         #1;
         compare_now();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
